// File: rtl/mpmc9_pkg.sv
// mpmc9_pkg: shared constants and types for the mpmc9 cache write-side controller.
//   CACHE_ASSOC/CACHE_SETS/TAG_LSB  cache geometry
//   mpmc9_cache_line_t              cache write-port payload {tag, data}
//   mpmc9_fill_op_t                 request op encoding
//   mpmc9_shadow_t                  shadow tag directory entry {valid, tag}
package mpmc9_pkg;
    localparam int CACHE_ASSOC = 8;
    localparam int CACHE_SETS  = 128;
    localparam int TAG_LSB     = 13;
    localparam int TAG_W       = 32 - TAG_LSB;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [255:0]     data;
    } mpmc9_cache_line_t;

    typedef enum logic [1:0] {
        OP_FILL  = 2'd0,
        OP_STORE = 2'd1,
        OP_INV   = 2'd2,
        OP_RSVD  = 2'd3
    } mpmc9_fill_op_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } mpmc9_shadow_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ISSUE,
        ST_FLUSH
    } mpmc9_fill_state_t;
endpackage

// File: rtl/mpmc9_cache_fill_tag_dir.sv
// mpmc9_tag_dir: shadow tag directory and per-set round-robin pointers.
//   clk, rst_n                 clock, async active-low reset (clears valids and pointers)
//   lk_set_i, lk_tag_i         combinational lookup key
//   lk_hit_o, lk_hway_o        resident flag and lowest matching way
//   lk_victim_o, lk_full_o     replacement way and "no invalid way in set"
//   wr_en_i/wr_set_i/wr_way_i/wr_ent_i  entry write (clear by writing valid=0)
//   rr_adv_i                   advance rr pointer of wr_set_i
//   rr_clr_i                   clear every rr pointer
module mpmc9_tag_dir import mpmc9_pkg::*; #(
    parameter int WAYS = CACHE_ASSOC,
    parameter int SETS = CACHE_SETS,
    localparam int WW  = $clog2(WAYS),
    localparam int IW  = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IW-1:0]    lk_set_i,
    input  logic [TAG_W-1:0] lk_tag_i,
    output logic             lk_hit_o,
    output logic [WW-1:0]    lk_hway_o,
    output logic [WW-1:0]    lk_victim_o,
    output logic             lk_full_o,
    input  logic             wr_en_i,
    input  logic [IW-1:0]    wr_set_i,
    input  logic [WW-1:0]    wr_way_i,
    input  mpmc9_shadow_t    wr_ent_i,
    input  logic             rr_adv_i,
    input  logic             rr_clr_i
);
    mpmc9_shadow_t dir_q [SETS][WAYS];
    logic [WW-1:0] rr_q  [SETS];
    logic [WW-1:0] inv_way;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) dir_q[s][w] <= '0;
            end
        end else begin
            if (wr_en_i) dir_q[wr_set_i][wr_way_i] <= wr_ent_i;
            if (rr_clr_i) begin
                for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
            end else if (rr_adv_i) begin
                rr_q[wr_set_i] <= (rr_q[wr_set_i] == WW'(WAYS - 1)) ? '0 : rr_q[wr_set_i] + 1'b1;
            end
        end
    end

    // Scanning from the top way down leaves the lowest matching/invalid way.
    always_comb begin
        lk_hit_o  = 1'b0;
        lk_hway_o = '0;
        lk_full_o = 1'b1;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (dir_q[lk_set_i][w].valid && dir_q[lk_set_i][w].tag == lk_tag_i) begin
                lk_hit_o  = 1'b1;
                lk_hway_o = WW'(w);
            end
            if (!dir_q[lk_set_i][w].valid) begin
                lk_full_o = 1'b0;
                inv_way   = WW'(w);
            end
        end
    end

    assign lk_victim_o = lk_hit_o ? lk_hway_o : !lk_full_o ? inv_way : rr_q[lk_set_i];
endmodule

// File: rtl/mpmc9_cache_fill.sv
// mpmc9_cache_fill: write-side controller for the mpmc9 read cache.
//   clk, rst_n                      clock, async active-low reset
//   req_valid_i/req_ready_o         request handshake (ready only in IDLE)
//   req_op_i, req_adr_i, req_sel_i, req_dat_i   FILL/STORE/INV request payload
//   flush_i                         whole-cache invalidate pulse
//   done_o, done_hit_o, done_way_o  completion pulse with lookup result
//   busy_o                          not IDLE
//   wr_o, wway_o, wadr_o, wdat_o, inv_o   cache write port
module mpmc9_cache_fill #(
    parameter int WAYS    = mpmc9_pkg::CACHE_ASSOC,
    parameter int SETS    = mpmc9_pkg::CACHE_SETS,
    parameter int TAG_LSB = mpmc9_pkg::TAG_LSB
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_op_i,
    input  logic [31:0]                  req_adr_i,
    input  logic [31:0]                  req_sel_i,
    input  logic [255:0]                 req_dat_i,
    input  logic                         flush_i,
    output logic                         done_o,
    output logic                         done_hit_o,
    output logic [2:0]                   done_way_o,
    output logic                         busy_o,
    output logic [31:0]                  wr_o,
    output logic [2:0]                   wway_o,
    output logic [31:0]                  wadr_o,
    output mpmc9_pkg::mpmc9_cache_line_t wdat_o,
    output logic                         inv_o
);
    import mpmc9_pkg::*;

    localparam int WW = $clog2(WAYS);
    localparam int IW = $clog2(SETS);
    localparam int CW = WW + IW;

    mpmc9_fill_state_t state_q, state_d;
    mpmc9_fill_op_t    op_q, op_d;
    logic [31:6]       adr_q, adr_d;
    logic [31:0]       sel_q, sel_d;
    logic [255:0]      dat_q, dat_d;
    logic              hit_q, hit_d, full_q, full_d, flush_pend_q, flush_pend_d;
    logic [WW-1:0]     hway_q, hway_d, vic_q, vic_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              lk_hit, lk_full;
    logic [WW-1:0]     lk_hway, lk_victim;
    logic              dir_we, rr_adv, rr_clr;
    logic [IW-1:0]     dir_set;
    logic [WW-1:0]     dir_way;
    mpmc9_shadow_t     dir_ent;
    logic              unused_adr_lsb;

    assign unused_adr_lsb = ^req_adr_i[5:0];

    mpmc9_tag_dir #(.WAYS(WAYS), .SETS(SETS)) u_dir (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_set_i   (adr_q[TAG_LSB-1:6]),
        .lk_tag_i   (adr_q[31:TAG_LSB]),
        .lk_hit_o   (lk_hit),
        .lk_hway_o  (lk_hway),
        .lk_victim_o(lk_victim),
        .lk_full_o  (lk_full),
        .wr_en_i    (dir_we),
        .wr_set_i   (dir_set),
        .wr_way_i   (dir_way),
        .wr_ent_i   (dir_ent),
        .rr_adv_i   (rr_adv),
        .rr_clr_i   (rr_clr)
    );

    // Gated by rst_n so ready stays low while reset is held.
    assign req_ready_o = rst_n && state_q == ST_IDLE && !flush_i && !flush_pend_q;
    assign busy_o      = state_q != ST_IDLE;
    assign wdat_o      = '{tag: adr_q[31:TAG_LSB], data: dat_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_FILL;
            adr_q        <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            hit_q        <= 1'b0;
            full_q       <= 1'b0;
            hway_q       <= '0;
            vic_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            dat_q        <= dat_d;
            hit_q        <= hit_d;
            full_q       <= full_d;
            hway_q       <= hway_d;
            vic_q        <= vic_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_q ? flush_pend_d : flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        dat_d        = dat_q;
        hit_d        = hit_q;
        full_d       = full_q;
        hway_d       = hway_q;
        vic_d        = vic_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | (flush_i && state_q != ST_IDLE);
        wr_o         = '0;
        inv_o        = 1'b0;
        done_o       = 1'b0;
        done_hit_o   = 1'b0;
        done_way_o   = '0;
        wway_o       = op_q == OP_FILL ? vic_q : hway_q;
        wadr_o       = {adr_q, 6'b0};
        dir_we       = 1'b0;
        dir_set      = adr_q[TAG_LSB-1:6];
        dir_way      = wway_o;
        dir_ent      = '{valid: 1'b1, tag: adr_q[31:TAG_LSB]};
        rr_adv       = 1'b0;
        rr_clr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i || flush_pend_q) begin
                    state_d      = ST_FLUSH;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (req_valid_i) begin
                    state_d = ST_LOOKUP;
                    op_d    = mpmc9_fill_op_t'(req_op_i);
                    adr_d   = req_adr_i[31:6];
                    sel_d   = req_sel_i;
                    dat_d   = req_dat_i;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_ISSUE;
                hit_d   = lk_hit;
                full_d  = lk_full;
                hway_d  = lk_hway;
                vic_d   = lk_victim;
            end
            ST_ISSUE: begin
                state_d    = ST_IDLE;
                done_o     = 1'b1;
                done_hit_o = hit_q && op_q != OP_RSVD;
                done_way_o = wway_o;
                case (op_q)
                    OP_FILL: begin
                        wr_o   = '1;
                        dir_we = 1'b1;
                        // Pointer only moves when a valid line is actually evicted.
                        rr_adv = !hit_q && full_q;
                    end
                    OP_STORE: wr_o = hit_q ? sel_q : '0;
                    OP_INV: begin
                        inv_o         = hit_q;
                        dir_we        = hit_q;
                        dir_ent.valid = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_FLUSH: begin
                inv_o   = 1'b1;
                wway_o  = cnt_q[WW-1:0];
                wadr_o  = {{(32 - TAG_LSB){1'b0}}, cnt_q[CW-1:WW], 6'b0};
                dir_we  = 1'b1;
                dir_set = cnt_q[CW-1:WW];
                dir_way = cnt_q[WW-1:0];
                dir_ent = '0;
                cnt_d   = cnt_q + 1'b1;
                // done coincides with the last invalidate cycle.
                if (&cnt_q) begin
                    done_o  = 1'b1;
                    rr_clr  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mpmc9_cache_fill.sv
// tb_mpmc9_cache_fill: directed table-driven bench for mpmc9_cache_fill.
module tb_mpmc9_cache_fill;
    import mpmc9_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0, req_ready;
    logic [1:0]        req_op = '0;
    logic [31:0]       req_adr = '0, req_sel = '0;
    logic [255:0]      req_dat = '0;
    logic              flush = 1'b0;
    logic              done, done_hit, busy, inv;
    logic [2:0]        done_way, wway;
    logic [31:0]       wr, wadr;
    mpmc9_cache_line_t wdat;
    int                checks = 0;
    int                failures = 0;

    mpmc9_cache_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i   (req_op),
        .req_adr_i  (req_adr),
        .req_sel_i  (req_sel),
        .req_dat_i  (req_dat),
        .flush_i    (flush),
        .done_o     (done),
        .done_hit_o (done_hit),
        .done_way_o (done_way),
        .busy_o     (busy),
        .wr_o       (wr),
        .wway_o     (wway),
        .wadr_o     (wadr),
        .wdat_o     (wdat),
        .inv_o      (inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] adr;
        logic [31:0] sel;
        logic [31:0] ewr;
        logic        einv;
        logic        ehit;
        logic [2:0]  eway;
        logic        cway;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [18:0] tag, input logic [6:0] set,
                                input logic [31:0] sel, input logic [31:0] ewr, input logic einv,
                                input logic ehit, input logic [2:0] eway, input logic cway);
        vec_t v;
        v.op = op; v.adr = {tag, set, 6'h2A}; v.sel = sel; v.ewr = ewr;
        v.einv = einv; v.ehit = ehit; v.eway = eway; v.cway = cway;
        return v;
    endfunction

    // Issues one request and checks the ISSUE cycle; returns at the ISSUE-cycle negedge.
    task automatic run(input vec_t v, input string nm);
        int n, lat;
        logic [255:0] dat;
        dat = {8{v.adr ^ 32'hA5A5_0000}};
        req_op = v.op; req_adr = v.adr; req_sel = v.sel; req_dat = dat; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_accept"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'd2);
        chk({nm, "_wr"}, 64'(wr), 64'(v.ewr));
        chk({nm, "_inv"}, 64'(inv), 64'(v.einv));
        chk({nm, "_hit"}, 64'(done_hit), 64'(v.ehit));
        chk({nm, "_wadr"}, 64'(wadr), 64'(v.adr & 32'hFFFF_FFC0));
        chk({nm, "_tag"}, 64'(wdat.tag), 64'(v.adr[31:13]));
        chk({nm, "_data"}, wdat.data[63:0], dat[63:0]);
        if (v.cway) begin
            chk({nm, "_wway"}, 64'(wway), 64'(v.eway));
            chk({nm, "_dway"}, 64'(done_way), 64'(v.eway));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int n, errs;
        logic [9:0] idx;

        #3;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_inv", 64'(inv), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(req_ready), 64'd1);

        // Set 0x0D: fill all ways, then round-robin eviction, store/inv hits and misses.
        tbl.push_back(mk(2'd0, 19'd9, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd0, 1));
        for (int k = 1; k < 8; k++)
            tbl.push_back(mk(2'd0, 19'(9 + k), 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'(k), 1));
        tbl.push_back(mk(2'd0, 19'd17, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd0, 1));
        tbl.push_back(mk(2'd0, 19'd18, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd1, 1));
        tbl.push_back(mk(2'd0, 19'd9, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd2, 1));
        tbl.push_back(mk(2'd1, 19'd12, 7'h0D, 32'h0000_00F0, 32'h0000_00F0, 0, 1, 3'd3, 1));
        tbl.push_back(mk(2'd1, 19'd10, 7'h0D, 32'h0000_00F0, 32'h0, 0, 0, 3'd0, 0));
        tbl.push_back(mk(2'd0, 19'd12, 7'h0D, 0, 32'hFFFF_FFFF, 0, 1, 3'd3, 1));
        tbl.push_back(mk(2'd2, 19'd13, 7'h0D, 0, 32'h0, 1, 1, 3'd4, 1));
        tbl.push_back(mk(2'd2, 19'd13, 7'h0D, 0, 32'h0, 0, 0, 3'd0, 0));
        tbl.push_back(mk(2'd0, 19'd20, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd4, 1));
        tbl.push_back(mk(2'd0, 19'd21, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd3, 1));
        tbl.push_back(mk(2'd3, 19'd21, 7'h0D, 32'hFFFF_FFFF, 32'h0, 0, 0, 3'd0, 0));
        tbl.push_back(mk(2'd1, 19'd21, 7'h0D, 32'hFFFF_0000, 32'hFFFF_0000, 0, 1, 3'd3, 1));
        tbl.push_back(mk(2'd0, 19'h7FFFF, 7'h7F, 0, 32'hFFFF_FFFF, 0, 0, 3'd0, 1));
        tbl.push_back(mk(2'd1, 19'd12, 7'h0D, 32'h1, 32'h0, 0, 0, 3'd0, 0));
        foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

        // Flush and request together: flush wins, request waits out the flush.
        @(negedge clk);
        flush = 1'b1;
        #1;
        fork
            run(mk(2'd0, 19'd9, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd0, 1), "postflush");
            begin
                chk("flush_prio_ready", 64'(req_ready), 64'd0);
                @(negedge clk);
                flush = 1'b0;
                errs = 0;
                for (int i = 0; i < 1024; i++) begin
                    idx = {wadr[12:6], wway};
                    if (inv !== 1'b1 || wr !== 32'h0 || idx !== 10'(i) || busy !== 1'b1 ||
                        done !== (i == 1023))
                        errs++;
                    if (i == 1023) chk("flush_done", 64'(done), 64'd1);
                    else @(negedge clk);
                end
                chk("flush_seq_errs", 64'(errs), 64'd0);
            end
        join

        // rr pointers cleared by flush: after 8 fills the 9th evicts way 0.
        for (int k = 1; k < 8; k++)
            run(mk(2'd0, 19'(9 + k), 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'(k), 1), $sformatf("pf%0d", k));
        run(mk(2'd0, 19'd17, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd0, 1), "pf_rr");
        run(mk(2'd1, 19'h7FFFF, 7'h7F, 32'hF, 32'h0, 0, 0, 3'd0, 0), "pf_miss_store");
        run(mk(2'd2, 19'd21, 7'h0D, 0, 32'h0, 0, 0, 3'd0, 0), "pf_miss_inv");

        // Flush pulse while busy is remembered and serviced at the next IDLE.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("pend_ready", 64'(req_ready), 64'd0);
        chk("pend_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("pend_busy", 64'(busy), 64'd1);
        chk("pend_inv", 64'(inv), 64'd1);
        n = 0;
        while (!done && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("pend_done", 64'(done), 64'd1);
        run(mk(2'd0, 19'h7FFFF, 7'h7F, 0, 32'hFFFF_FFFF, 0, 0, 3'd0, 1), "refill7f");

        // Reset in the middle of a flush.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (500) @(negedge clk);
        chk("mid_idx", 64'({wadr[12:6], wway}), 64'd500);
        chk("mid_inv", 64'(inv), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_inv", 64'(inv), 64'd0);
        chk("arst_wr", 64'(wr), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arel_ready", 64'(req_ready), 64'd1);
        run(mk(2'd1, 19'h7FFFF, 7'h7F, 32'hFFFF_FFFF, 32'h0, 0, 0, 3'd0, 0), "ar_store_miss");
        run(mk(2'd0, 19'd5, 7'h0D, 0, 32'hFFFF_FFFF, 0, 0, 3'd0, 1), "ar_fill");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
